// File: rtl/emmc_pkg.sv
// Shared types and constants for the eMMC DAT0 transfer engine.
// CRC framing is built only when EMMC_DAT_CRC_EN is defined.
package emmc_pkg;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    WR_START,
    WR_DATA,
    WR_CRC,
    WR_END,
    RD_WAIT,
    RD_DATA,
    RD_CRC,
    RD_END,
    DONE
  } xfer_state_e;

  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

endpackage

// File: rtl/emmc_crc16.sv
// Bit-serial CRC16-CCITT (x^16+x^12+x^5+1), init 0, shared by TX and RX.
// Instantiated only when EMMC_DAT_CRC_EN is defined.
module emmc_crc16
  import emmc_pkg::*;
(
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             din_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  assign fb = crc_o[CRC_W-1] ^ din_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[CRC_W-2:0], 1'b0}
             ^ (fb ? CRC16_POLY : '0);
    end
  end

endmodule

// File: rtl/emmc_dat_xfer.sv
// Single-DAT-line eMMC block frame engine (write serialize / read capture).
// Define EMMC_DAT_CRC_EN to add CRC16 generation and checking to frames.
module emmc_dat_xfer
  import emmc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 1023,
  parameter int TO_W       = 10
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              host_start_i,
  input  logic              host_we_i,
  input  logic [DATA_W-1:0] host_wr_dat_i,
  output logic              host_ready_o,
  output logic [DATA_W-1:0] host_rd_dat_o,
  output logic              host_done_o,
  output logic              host_err_o,
  output logic              dat_o,
  output logic              dat_oe_o,
  input  logic              dat_i
);

  localparam int LEN_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W   = $clog2(LEN_MAX);

  xfer_state_e       state;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              last_dat;

  assign last_dat = (cnt == CNT_W'(DATA_W - 1));

`ifdef EMMC_DAT_CRC_EN
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] crc_sh;
  logic             last_crc;
  logic             crc_clr;
  logic             crc_en;
  logic             crc_din;

  assign last_crc = (cnt == CNT_W'(CRC_W - 1));

  // TX feeds each data bit as it is launched; RX feeds each sampled bit.
  always_comb begin
    crc_clr = (state == IDLE);
    crc_en  = 1'b0;
    crc_din = 1'b0;
    if (state == WR_START || (state == WR_DATA && !last_dat)) begin
      crc_en  = 1'b1;
      crc_din = tx_sh[DATA_W-1];
    end else if (state == RD_DATA) begin
      crc_en  = 1'b1;
      crc_din = dat_i;
    end
  end

  emmc_crc16 u_crc (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .din_i  (crc_din),
    .crc_o  (crc)
  );
`endif

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state         <= INIT;
      host_ready_o  <= 1'b0;
      host_done_o   <= 1'b0;
      host_err_o    <= 1'b0;
      host_rd_dat_o <= '0;
      dat_o         <= 1'b1;
      dat_oe_o      <= 1'b0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      cnt           <= '0;
      to_cnt        <= '0;
`ifdef EMMC_DAT_CRC_EN
      crc_sh        <= '0;
`endif
    end else begin
      host_done_o <= 1'b0;
      host_err_o  <= 1'b0;
      case (state)
        INIT: begin
          state        <= IDLE;
          host_ready_o <= 1'b1;
        end
        IDLE: begin
          if (host_start_i && host_ready_o) begin
            host_ready_o <= 1'b0;
            cnt          <= '0;
            to_cnt       <= '0;
            if (host_we_i) begin
              tx_sh    <= host_wr_dat_i;
              dat_o    <= START_BIT;
              dat_oe_o <= 1'b1;
              state    <= WR_START;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        WR_START: begin
          dat_o <= tx_sh[DATA_W-1];
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          state <= WR_DATA;
        end
        WR_DATA: begin
          if (last_dat) begin
            cnt <= '0;
`ifdef EMMC_DAT_CRC_EN
            dat_o  <= crc[CRC_W-1];
            crc_sh <= {crc[CRC_W-2:0], 1'b0};
            state  <= WR_CRC;
`else
            dat_o <= END_BIT;
            state <= WR_END;
`endif
          end else begin
            dat_o <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
          end
        end
`ifdef EMMC_DAT_CRC_EN
        WR_CRC: begin
          if (last_crc) begin
            dat_o <= END_BIT;
            state <= WR_END;
          end else begin
            dat_o  <= crc_sh[CRC_W-1];
            crc_sh <= {crc_sh[CRC_W-2:0], 1'b0};
            cnt    <= cnt + 1'b1;
          end
        end
`endif
        WR_END: begin
          dat_o       <= 1'b1;
          dat_oe_o    <= 1'b0;
          host_done_o <= 1'b1;
          state       <= DONE;
        end
        RD_WAIT: begin
          if (dat_i == START_BIT) begin
            cnt   <= '0;
            state <= RD_DATA;
          end else if (to_cnt == TO_W'(RD_TIMEOUT - 1)) begin
            host_done_o <= 1'b1;
            host_err_o  <= 1'b1;
            state       <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RD_DATA: begin
          rx_sh <= {rx_sh[DATA_W-2:0], dat_i};
          if (last_dat) begin
            cnt <= '0;
`ifdef EMMC_DAT_CRC_EN
            state <= RD_CRC;
`else
            state <= RD_END;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef EMMC_DAT_CRC_EN
        RD_CRC: begin
          crc_sh <= {crc_sh[CRC_W-2:0], dat_i};
          if (last_crc) begin
            state <= RD_END;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        RD_END: begin
          host_rd_dat_o <= rx_sh;
          host_done_o   <= 1'b1;
`ifdef EMMC_DAT_CRC_EN
          host_err_o <= (dat_i != END_BIT) || (crc_sh != crc);
`else
          host_err_o <= (dat_i != END_BIT);
`endif
          state <= DONE;
        end
        DONE: begin
          host_ready_o <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          host_ready_o <= 1'b0;
          dat_o        <= 1'b1;
          dat_oe_o     <= 1'b0;
          state        <= INIT;
        end
      endcase
    end
  end

endmodule
